// File: rtl/mem_arbiter_if.sv
// Cache-port and RAM-port bundle for mem_arbiter.
// A cache raises REN/WEN with address/data and holds them until its wait drops for one cycle;
// that low cycle completes one word, and dload/iload are valid only in that cycle.
interface mem_arbiter_if #(
    parameter int NCPU = 2
);
    logic [NCPU-1:0]    dREN;
    logic [NCPU-1:0]    dWEN;
    logic [NCPU*32-1:0] daddr;
    logic [NCPU*32-1:0] dstore;
    logic [NCPU-1:0]    dwait;
    logic [NCPU*32-1:0] dload;
    logic [NCPU-1:0]    iREN;
    logic [NCPU*32-1:0] iaddr;
    logic [NCPU-1:0]    iwait;
    logic [NCPU*32-1:0] iload;
    logic               ramREN;
    logic               ramWEN;
    logic [31:0]        ramaddr;
    logic [31:0]        ramstore;
    logic [31:0]        ramload;
    logic [1:0]         ramstate;
    logic               ram_err;

    modport slave (
        input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
        input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of per-CPU dcache/icache word requests onto a single RAM port.
// A grant is held for up to BLOCK_WORDS words so block transfers never interleave.
module mem_arbiter #(
    parameter int NCPU        = 2,
    parameter int BLOCK_WORDS = 2,
    localparam int OW = (NCPU > 1) ? $clog2(NCPU) : 1,
    localparam int WW = $clog2(BLOCK_WORDS + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  arb,
    output logic [1:0]    dbg_state,
    output logic [OW-1:0] dbg_owner,
    output logic [OW-1:0] dbg_d_rr,
    output logic [OW-1:0] dbg_i_rr,
    output logic [WW-1:0] dbg_wcnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, DGNT = 2'd1, IGNT = 2'd2} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   d_rr;
    logic [OW-1:0]   i_rr;
    logic [WW-1:0]   wcnt;
    logic            ram_err_q;
    logic [NCPU-1:0] d_req;
    logic            owner_req;
    logic            complete;
    logic            last_word;

    assign d_req = arb.dREN | arb.dWEN;

    // First requester found scanning rr, rr+1, ... modulo NCPU.
    function automatic logic [OW-1:0] pick(input logic [NCPU-1:0] req, input logic [OW-1:0] rr);
        logic [OW-1:0] sel;
        logic          found;
        sel   = rr;
        found = 1'b0;
        for (int k = 0; k < NCPU; k++) begin
            int idx;
            idx = (int'(rr) + k) % NCPU;
            if (!found && req[idx]) begin
                sel   = OW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [OW-1:0] next_of(input logic [OW-1:0] cur);
        return OW'((int'(cur) + 1) % NCPU);
    endfunction

    always_comb begin
        owner_req = 1'b0;
        case (state)
            DGNT:    owner_req = d_req[owner];
            IGNT:    owner_req = arb.iREN[owner];
            default: owner_req = 1'b0;
        endcase
        complete  = owner_req && (arb.ramstate == RAM_ACCESS);
        last_word = complete && (int'(wcnt) + 1 >= BLOCK_WORDS);
    end

    // RAM port and cache responses follow the current grant combinationally.
    always_comb begin
        arb.dwait    = '1;
        arb.iwait    = '1;
        arb.dload    = '0;
        arb.iload    = '0;
        arb.ramREN   = 1'b0;
        arb.ramWEN   = 1'b0;
        arb.ramaddr  = '0;
        arb.ramstore = '0;
        case (state)
            DGNT: begin
                arb.ramaddr               = arb.daddr[32*owner +: 32];
                arb.ramstore              = arb.dstore[32*owner +: 32];
                arb.ramWEN                = arb.dWEN[owner];
                arb.ramREN                = arb.dREN[owner] & ~arb.dWEN[owner];
                arb.dwait[owner]          = ~complete;
                arb.dload[32*owner +: 32] = arb.ramload;
            end
            IGNT: begin
                arb.ramaddr               = arb.iaddr[32*owner +: 32];
                arb.ramREN                = arb.iREN[owner];
                arb.iwait[owner]          = ~complete;
                arb.iload[32*owner +: 32] = arb.ramload;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            owner     <= '0;
            d_rr      <= '0;
            i_rr      <= '0;
            wcnt      <= '0;
            ram_err_q <= 1'b0;
        end else begin
            if (state != IDLE && arb.ramstate == RAM_ERROR)
                ram_err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (|d_req) begin
                        state <= DGNT;
                        owner <= pick(d_req, d_rr);
                    end else if (|arb.iREN) begin
                        state <= IGNT;
                        owner <= pick(arb.iREN, i_rr);
                    end
                end
                DGNT, IGNT: begin
                    if (!owner_req || last_word) begin
                        state <= IDLE;
                        wcnt  <= '0;
                        if (state == DGNT) d_rr <= next_of(owner);
                        else               i_rr <= next_of(owner);
                    end else if (complete) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.ram_err = ram_err_q;
    assign dbg_state   = state;
    assign dbg_owner   = owner;
    assign dbg_d_rr    = d_rr;
    assign dbg_i_rr    = i_rr;
    assign dbg_wcnt    = wcnt;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cache agents fed from command queues, a latency RAM model,
// and per-port expected-data queues checked whenever a wait drops.
module tb_mem_arbiter;
    localparam int NCPU = 2;
    localparam int BW   = 2;
    localparam int LAT  = 2;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [1:0] dbg_state;
    logic [0:0] dbg_owner, dbg_d_rr, dbg_i_rr;
    logic [1:0] dbg_wcnt;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.NCPU(NCPU)) bus ();

    mem_arbiter #(.NCPU(NCPU), .BLOCK_WORDS(BW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .arb       (bus),
        .dbg_state (dbg_state),
        .dbg_owner (dbg_owner),
        .dbg_d_rr  (dbg_d_rr),
        .dbg_i_rr  (dbg_i_rr),
        .dbg_wcnt  (dbg_wcnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // RAM model: one BUSY cycle then ACCESS per word; unwritten words hold an address pattern.
    bit [31:0] ram_mem [256];
    bit        ram_wr  [256];
    int        ram_cnt = 0;
    logic      force_err = 1'b0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
    endfunction

    always_comb begin
        bus.ramstate = 2'd0;
        if (bus.ramREN || bus.ramWEN) begin
            if (force_err)             bus.ramstate = 2'd3;
            else if (ram_cnt >= LAT-1) bus.ramstate = 2'd2;
            else                       bus.ramstate = 2'd1;
        end
    end

    assign bus.ramload = ram_wr[bus.ramaddr[9:2]] ? ram_mem[bus.ramaddr[9:2]] : init_word(bus.ramaddr);

    always @(posedge CLK) begin
        ram_cnt <= ((bus.ramREN || bus.ramWEN) && bus.ramstate != 2'd2) ? ram_cnt + 1 : 0;
        if (bus.ramWEN && bus.ramstate == 2'd2) begin
            ram_mem[bus.ramaddr[9:2]] <= bus.ramstore;
            ram_wr[bus.ramaddr[9:2]]  <= 1'b1;
        end
    end

    // Reference memory, updated when stimulus is queued.
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : init_word(a);
    endfunction

    logic [64:0] d_cmd_q [NCPU][$];
    logic [31:0] i_cmd_q [NCPU][$];
    logic [31:0] d_exp_q [NCPU][$];
    logic [31:0] i_exp_q [NCPU][$];
    int          done_log[$];
    int          idle_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_d(input int cpu, input bit we, input logic [31:0] addr, input logic [31:0] data);
        d_cmd_q[cpu].push_back({we, addr, data});
        if (we) begin
            ref_mem[addr[9:2]] = data;
            ref_wr[addr[9:2]]  = 1'b1;
        end else begin
            d_exp_q[cpu].push_back(ref_read(addr));
        end
    endtask

    task automatic push_i(input int cpu, input logic [31:0] addr);
        i_cmd_q[cpu].push_back(addr);
        i_exp_q[cpu].push_back(ref_read(addr));
    endtask

    task automatic drive();
        logic [64:0] cmd;
        for (int i = 0; i < NCPU; i++) begin
            if (d_cmd_q[i].size() > 0) begin
                cmd                     = d_cmd_q[i][0];
                bus.dWEN[i]             = cmd[64];
                bus.dREN[i]             = ~cmd[64];
                bus.daddr[32*i +: 32]   = cmd[63:32];
                bus.dstore[32*i +: 32]  = cmd[31:0];
            end else begin
                bus.dREN[i] = 1'b0;
                bus.dWEN[i] = 1'b0;
            end
            if (i_cmd_q[i].size() > 0) begin
                bus.iREN[i]           = 1'b1;
                bus.iaddr[32*i +: 32] = i_cmd_q[i][0];
            end else begin
                bus.iREN[i] = 1'b0;
            end
        end
    endtask

    task automatic sample();
        logic [64:0] cmd;
        logic [31:0] exp;
        if (dbg_state == 2'd0 && (bus.dREN | bus.dWEN | bus.iREN) != '0) idle_req++;
        check("one_wait_low", 32'($countones(~{bus.dwait, bus.iwait}) <= 1), 32'd1);
        for (int i = 0; i < NCPU; i++) begin
            if (!(bus.dREN[i] || bus.dWEN[i])) begin
                check("dwait_no_req", 32'(bus.dwait[i]), 32'd1);
            end else if (!bus.dwait[i]) begin
                done_log.push_back(i);
                if (d_cmd_q[i].size() == 0) begin
                    check("d_cmd_underflow", 32'd0, 32'd1);
                end else begin
                    cmd = d_cmd_q[i].pop_front();
                    check("d_ramaddr", bus.ramaddr, cmd[63:32]);
                    if (cmd[64]) begin
                        check("d_ramWEN", 32'(bus.ramWEN), 32'd1);
                        check("d_ramstore", bus.ramstore, cmd[31:0]);
                    end else begin
                        check("d_ramREN", 32'(bus.ramREN), 32'd1);
                        exp = (d_exp_q[i].size() > 0) ? d_exp_q[i].pop_front() : 32'hxxxxxxxx;
                        check("dload", bus.dload[32*i +: 32], exp);
                    end
                end
            end
            if (!bus.iREN[i]) begin
                check("iwait_no_req", 32'(bus.iwait[i]), 32'd1);
            end else if (!bus.iwait[i]) begin
                done_log.push_back(10 + i);
                if (i_cmd_q[i].size() == 0) begin
                    check("i_cmd_underflow", 32'd0, 32'd1);
                end else begin
                    check("i_ramaddr", bus.ramaddr, i_cmd_q[i].pop_front());
                    exp = (i_exp_q[i].size() > 0) ? i_exp_q[i].pop_front() : 32'hxxxxxxxx;
                    check("iload", bus.iload[32*i +: 32], exp);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #1;
        drive();
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (dbg_state == 2'd0) && ((bus.dREN | bus.dWEN | bus.iREN) == '0);
        for (int i = 0; i < NCPU; i++)
            if (d_cmd_q[i].size() != 0 || i_cmd_q[i].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic run(input string tag, input int budget);
        bit done;
        done = 1'b0;
        idle_req = 0;
        done_log.delete();
        drive();
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = all_idle();
        end
        check({tag, "_finished"}, 32'(done), 32'd1);
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check({tag, "_words"}, 32'(done_log.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < done_log.size(); k++)
            check({tag, "_order"}, 32'(done_log[k]), 32'(exp[k]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_log[$];
        nRST       = 1'b0;
        bus.dREN   = '0;
        bus.dWEN   = '0;
        bus.iREN   = '0;
        bus.daddr  = '0;
        bus.dstore = '0;
        bus.iaddr  = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_dwait", 32'(bus.dwait), 32'h3);
        check("rst_iwait", 32'(bus.iwait), 32'h3);
        check("rst_ramREN", 32'(bus.ramREN), 32'd0);
        check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("rst_ramaddr", bus.ramaddr, 32'd0);
        check("rst_dload", bus.dload[31:0] | bus.dload[63:32], 32'd0);
        check("rst_iload", bus.iload[31:0] | bus.iload[63:32], 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ram_err", 32'(bus.ram_err), 32'd0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Single read through a two-cycle RAM.
        push_d(0, 1'b0, 32'h40, 32'h0);
        run("t1", 40);
        exp_log = '{0};
        check_log("t1", exp_log);
        check("t1_idle_req", 32'(idle_req), 32'd1);
        check("t1_d_rr", 32'(dbg_d_rr), 32'd1);

        // Two-word writeback inside one grant.
        push_d(0, 1'b1, 32'h80, 32'h11);
        push_d(0, 1'b1, 32'h84, 32'h22);
        run("t2", 40);
        exp_log = '{0, 0};
        check_log("t2", exp_log);
        check("t2_idle_req", 32'(idle_req), 32'd1);
        check("t2_mem80", ram_mem[32'h80 >> 2], 32'h11);
        check("t2_mem84", ram_mem[32'h84 >> 2], 32'h22);
        check("t2_d_rr", 32'(dbg_d_rr), 32'd1);

        // Bring d_rr back to CPU0, then both dcaches request together.
        push_d(1, 1'b0, 32'h84, 32'h0);
        run("t3a", 40);
        check("t3a_d_rr", 32'(dbg_d_rr), 32'd0);
        push_d(0, 1'b0, 32'h100, 32'h0);
        push_d(0, 1'b0, 32'h104, 32'h0);
        push_d(1, 1'b0, 32'h180, 32'h0);
        push_d(1, 1'b0, 32'h184, 32'h0);
        run("t3", 60);
        exp_log = '{0, 0, 1, 1};
        check_log("t3", exp_log);
        check("t3_idle_req", 32'(idle_req), 32'd2);
        check("t3_d_rr", 32'(dbg_d_rr), 32'd0);

        // Dcache beats a simultaneous icache request.
        push_i(1, 32'h200);
        push_d(0, 1'b0, 32'h240, 32'h0);
        run("t4", 60);
        exp_log = '{0, 11};
        check_log("t4", exp_log);
        check("t4_idle_req", 32'(idle_req), 32'd2);
        check("t4_i_rr", 32'(dbg_i_rr), 32'd0);

        // Three words held under one request: forced release after BW words.
        push_d(1, 1'b0, 32'h300, 32'h0);
        push_d(1, 1'b0, 32'h304, 32'h0);
        push_d(1, 1'b0, 32'h308, 32'h0);
        run("t5", 60);
        exp_log = '{1, 1, 1};
        check_log("t5", exp_log);
        check("t5_idle_req", 32'(idle_req), 32'd2);
        check("t5_d_rr", 32'(dbg_d_rr), 32'd0);

        // RAM error under an active grant, then asynchronous reset mid-transfer.
        force_err = 1'b1;
        push_d(0, 1'b0, 32'h40, 32'h0);
        drive();
        for (int c = 0; c < 6; c++) begin
            step();
            check("t6_dwait_err", 32'(bus.dwait[0]), 32'd1);
        end
        check("t6_ram_err", 32'(bus.ram_err), 32'd1);
        check("t6_state_dgnt", 32'(dbg_state), 32'd1);
        nRST = 1'b0;
        #1;
        check("t6_rst_ram_err", 32'(bus.ram_err), 32'd0);
        check("t6_rst_dwait", 32'(bus.dwait), 32'h3);
        check("t6_rst_iwait", 32'(bus.iwait), 32'h3);
        check("t6_rst_state", 32'(dbg_state), 32'd0);
        check("t6_rst_ramREN", 32'(bus.ramREN), 32'd0);
        d_cmd_q[0].delete();
        d_exp_q[0].delete();
        force_err = 1'b0;
        drive();
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        check("t6_post_state", 32'(dbg_state), 32'd0);
        check("t6_post_ram_err", 32'(bus.ram_err), 32'd0);

        for (int i = 0; i < NCPU; i++)
            check("exp_q_drained", 32'(d_exp_q[i].size() + i_exp_q[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
